// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO bus initiator: takes one LSU load/store, checks alignment,
// issues one req_valid pulse, waits for req_ready (with timeout) and returns extended read data.
module mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_size,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [63:0] cpu_rdata,
  output logic        cpu_err,
  output logic        req_valid,
  output logic [15:0] req_addr,
  output logic [63:0] req_wdata,
  output logic        req_we,
  output logic [2:0]  req_size,
  input  logic        req_ready,
  input  logic [63:0] req_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bad_req;

  // Select the addressed lanes from the full 64-bit register image, then extend.
  function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] off,
                                          input logic [2:0] sz);
    logic [63:0] sh;
    logic [63:0] res;
    sh = data >> {off, 3'b000};
    case (sz[1:0])
      2'd0:    res = sz[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    res = sz[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = sz[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    case (cpu_size[1:0])
      2'd0:    bad_req = 1'b0;
      2'd1:    bad_req = cpu_addr[0];
      2'd2:    bad_req = |cpu_addr[1:0];
      default: bad_req = |cpu_addr[2:0];
    endcase
    if (cpu_size == 3'b111 || (cpu_we && cpu_size[2])) begin
      bad_req = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          rdata_d = 64'd0;
          err_d   = bad_req;
          state_d = bad_req ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (req_ready) begin
          rdata_d = we_q ? 64'd0 : extract(req_rdata, addr_q[2:0], size_q);
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 64'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_done  = (state_q == S_RESP);
  assign cpu_rdata = cpu_done ? rdata_q : 64'd0;
  assign cpu_err   = cpu_done & err_q;
  assign cpu_stall = ((state_q == S_IDLE) && cpu_valid) || (state_q == S_ISSUE) ||
                     (state_q == S_WAIT);
  assign req_valid = (state_q == S_ISSUE);
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_we    = we_q;
  assign req_size  = {1'b0, size_q[1:0]};

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed testbench for mmio_initiator (TIMEOUT_CYCLES=4): one task per scenario,
// cycle 0 is the negedge at which cpu_valid is first presented.
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [2:0]  cpu_size;
  logic [63:0] cpu_wdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [63:0] cpu_rdata;
  logic        req_valid, req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_size;
  logic        req_ready;
  logic [63:0] req_rdata;

  int passed = 0;
  int total  = 0;

  // observations from the last run_txn
  int          obs_nreq, obs_issue, obs_done_cyc, obs_ndone;
  logic [63:0] obs_rdata, obs_wdata;
  logic        obs_err, obs_we, obs_stall_ok, obs_idle_zero;
  logic [15:0] obs_addr;
  logic [2:0]  obs_size;

  mmio_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_size(req_size), .req_ready(req_ready), .req_rdata(req_rdata)
  );

  always #5 clk = ~clk;

  // Presents one request at cycle 0 and watches 20 cycles; req_ready pulses at ready_cyc (-1: never).
  task automatic run_txn(input logic [15:0] a, input logic we, input logic [2:0] sz,
                         input logic [63:0] wd, input logic [63:0] rd, input int ready_cyc);
    obs_nreq = 0; obs_issue = -1; obs_done_cyc = -1; obs_ndone = 0;
    obs_rdata = '0; obs_err = 1'b0; obs_stall_ok = 1'b1; obs_idle_zero = 1'b1;
    obs_addr = '0; obs_we = 1'b0; obs_size = '0; obs_wdata = '0;
    req_rdata = rd;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      cpu_valid = (c == 0);
      cpu_addr = a; cpu_we = we; cpu_size = sz; cpu_wdata = wd;
      req_ready = (c == ready_cyc);
      #1;
      if (req_valid) begin
        obs_nreq++; obs_issue = c;
        obs_addr = req_addr; obs_we = req_we; obs_size = req_size; obs_wdata = req_wdata;
      end
      if (cpu_done) begin
        if (obs_ndone == 0) begin
          obs_done_cyc = c; obs_rdata = cpu_rdata; obs_err = cpu_err;
          if (cpu_stall) obs_stall_ok = 1'b0;
        end
        obs_ndone++;
      end else begin
        if (obs_ndone == 0 && !cpu_stall) obs_stall_ok = 1'b0;
        if (cpu_rdata !== 64'd0 || cpu_err !== 1'b0) obs_idle_zero = 1'b0;
      end
      @(negedge clk);
    end
    cpu_valid = 1'b0; req_ready = 1'b0;
    $display("txn addr=%h we=%0d size=%0d: req=%0d done@%0d ndone=%0d rdata=%h err=%0d",
             a, we, sz, obs_nreq, obs_done_cyc, obs_ndone, obs_rdata, obs_err);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_size = '0;
    cpu_wdata = '0; req_ready = 1'b0; req_rdata = '0;
    #12;
    total++; if (cpu_done !== 1'b0 || cpu_stall !== 1'b0 || cpu_err !== 1'b0) $display("FAIL reset_ctl: done=%b stall=%b err=%b, want 0", cpu_done, cpu_stall, cpu_err); else passed++;
    total++; if (cpu_rdata !== 64'd0) $display("FAIL reset_rdata: got %h want 0", cpu_rdata); else passed++;
    total++; if (req_valid !== 1'b0 || req_we !== 1'b0 || req_addr !== 16'd0 || req_size !== 3'd0 || req_wdata !== 64'd0) $display("FAIL reset_req: v=%b we=%b a=%h s=%0d wd=%h, want 0", req_valid, req_we, req_addr, req_size, req_wdata); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_dword();
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h0000_0001_2345_6789, 2);
    total++; if (obs_nreq !== 1 || obs_issue !== 1) $display("FAIL ld_issue: nreq=%0d at %0d, want 1 at 1", obs_nreq, obs_issue); else passed++;
    total++; if (obs_size !== 3'd3 || obs_addr !== 16'hBFF8 || obs_we !== 1'b0) $display("FAIL ld_req: size=%0d addr=%h we=%b, want 3 bff8 0", obs_size, obs_addr, obs_we); else passed++;
    total++; if (obs_done_cyc !== 3 || obs_ndone !== 1) $display("FAIL ld_done: at %0d count %0d, want 3 count 1", obs_done_cyc, obs_ndone); else passed++;
    total++; if (obs_rdata !== 64'h0000_0001_2345_6789 || obs_err !== 1'b0) $display("FAIL ld_data: got %h err=%b want 0000000123456789 err=0", obs_rdata, obs_err); else passed++;
    total++; if (obs_stall_ok !== 1'b1 || obs_idle_zero !== 1'b1) $display("FAIL ld_stall: stall_ok=%b idle_zero=%b, want 1 1", obs_stall_ok, obs_idle_zero); else passed++;
  endtask

  task automatic test_load_extend();
    run_txn(16'hBFFC, 1'b0, 3'd2, 64'd0, 64'h8000_0000_0000_0010, 2);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_8000_0000 || obs_err !== 1'b0) $display("FAIL lw_sext: got %h want ffffffff80000000", obs_rdata); else passed++;
    run_txn(16'hBFFC, 1'b0, 3'd6, 64'd0, 64'h8000_0000_0000_0010, 2);
    total++; if (obs_rdata !== 64'h0000_0000_8000_0000) $display("FAIL lwu_zext: got %h want 0000000080000000", obs_rdata); else passed++;
    run_txn(16'hBFF8, 1'b0, 3'd4, 64'd0, 64'h8000_0000_0000_0010, 2);
    total++; if (obs_rdata !== 64'h10) $display("FAIL lbu: got %h want 10", obs_rdata); else passed++;
    run_txn(16'hBFFE, 1'b0, 3'd1, 64'd0, 64'h8000_0000_0000_0010, 2);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_8000) $display("FAIL lh_sext: got %h want ffffffffffff8000", obs_rdata); else passed++;
    run_txn(16'hBFFF, 1'b0, 3'd0, 64'd0, 64'h8000_0000_0000_0010, 2);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_sext: got %h want ffffffffffffff80", obs_rdata); else passed++;
  endtask

  task automatic test_store_byte();
    run_txn(16'h4003, 1'b1, 3'd0, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    total++; if (obs_nreq !== 1 || obs_addr !== 16'h4003 || obs_we !== 1'b1 || obs_size !== 3'd0) $display("FAIL sb_req: n=%0d addr=%h we=%b size=%0d, want 1 4003 1 0", obs_nreq, obs_addr, obs_we, obs_size); else passed++;
    total++; if (obs_wdata !== 64'hAB) $display("FAIL sb_wdata: got %h want ab", obs_wdata); else passed++;
    total++; if (obs_done_cyc !== 3 || obs_rdata !== 64'd0 || obs_err !== 1'b0) $display("FAIL sb_resp: done@%0d rdata=%h err=%b, want 3 0 0", obs_done_cyc, obs_rdata, obs_err); else passed++;
  endtask

  task automatic test_align_errors();
    logic [15:0] addrs [4] = '{16'h4002, 16'h4004, 16'h4000, 16'h4000};
    logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  sizes [4] = '{3'd2, 3'd3, 3'd7, 3'd4};
    for (int i = 0; i < 4; i++) begin
      run_txn(addrs[i], wes[i], sizes[i], 64'h55, 64'h1234, 2);
      total++; if (obs_nreq !== 0 || obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_ndone !== 1 || obs_rdata !== 64'd0) $display("FAIL align_%0d: nreq=%0d done@%0d err=%b ndone=%0d rdata=%h, want 0 1 1 1 0", i, obs_nreq, obs_done_cyc, obs_err, obs_ndone, obs_rdata); else passed++;
    end
  endtask

  task automatic test_timeout();
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h77, -1);
    total++; if (obs_done_cyc !== 6 || obs_err !== 1'b1 || obs_rdata !== 64'd0) $display("FAIL tmo: done@%0d err=%b rdata=%h, want 6 1 0", obs_done_cyc, obs_err, obs_rdata); else passed++;
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h77, 5);
    total++; if (obs_done_cyc !== 6 || obs_err !== 1'b0 || obs_rdata !== 64'h77) $display("FAIL tmo_ready_last: done@%0d err=%b rdata=%h, want 6 0 77", obs_done_cyc, obs_err, obs_rdata); else passed++;
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h99, 4);
    total++; if (obs_done_cyc !== 5 || obs_err !== 1'b0 || obs_rdata !== 64'h99) $display("FAIL tmo_ready_third: done@%0d err=%b rdata=%h, want 5 0 99", obs_done_cyc, obs_err, obs_rdata); else passed++;
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h77, 8);
    total++; if (obs_ndone !== 1 || obs_done_cyc !== 6 || obs_err !== 1'b1) $display("FAIL tmo_late_ready: ndone=%0d done@%0d err=%b, want 1 6 1", obs_ndone, obs_done_cyc, obs_err); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones;
    req_rdata = 64'h1111;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 16'hBFF8; cpu_we = 1'b0; cpu_size = 3'd3; cpu_wdata = 64'h42;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (cpu_stall !== 1'b1) $display("FAIL rstmid_in_wait: stall=%b want 1", cpu_stall); else passed++;
    reset = 1'b1;
    #1;
    total++; if (cpu_stall !== 1'b0 || cpu_done !== 1'b0 || req_valid !== 1'b0 || req_addr !== 16'd0 || req_size !== 3'd0 || req_wdata !== 64'd0 || cpu_rdata !== 64'd0 || cpu_err !== 1'b0) $display("FAIL rstmid_outputs: stall=%b done=%b rv=%b addr=%h size=%0d wd=%h, want all 0", cpu_stall, cpu_done, req_valid, req_addr, req_size, req_wdata); else passed++;
    @(negedge clk);
    reset = 1'b0; req_ready = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      #1; if (cpu_done) dones++;
      @(negedge clk);
      req_ready = 1'b0;
    end
    total++; if (dones !== 0) $display("FAIL rstmid_stray_ready: dones=%0d want 0", dones); else passed++;
    run_txn(16'hBFF8, 1'b0, 3'd3, 64'd0, 64'h0000_0001_2345_6789, 2);
    total++; if (obs_done_cyc !== 3 || obs_rdata !== 64'h0000_0001_2345_6789 || obs_err !== 1'b0) $display("FAIL rstmid_next_ld: done@%0d rdata=%h err=%b, want 3 0000000123456789 0", obs_done_cyc, obs_rdata, obs_err); else passed++;
  endtask

  task automatic test_back_to_back();
    int  nreq, ndone, d0, d1, r1;
    logic prev_rv;
    logic [63:0] rd0, rd1;
    nreq = 0; ndone = 0; d0 = -1; d1 = -1; r1 = -1; prev_rv = 1'b0; rd0 = '0; rd1 = '0;
    req_rdata = 64'h8000_0000_0000_0010;
    @(negedge clk);
    cpu_we = 1'b0; cpu_wdata = '0;
    for (int c = 0; c < 12; c++) begin
      cpu_valid = (c < 5);
      cpu_addr  = (c < 3) ? 16'hBFF8 : 16'hBFFC;
      cpu_size  = (c < 3) ? 3'd3 : 3'd6;
      req_ready = prev_rv;
      #1;
      prev_rv = req_valid;
      if (req_valid) begin nreq++; if (nreq == 2) r1 = c; end
      if (cpu_done) begin
        ndone++;
        if (ndone == 1) begin d0 = c; rd0 = cpu_rdata; end
        else begin d1 = c; rd1 = cpu_rdata; end
      end
      @(negedge clk);
    end
    cpu_valid = 1'b0; req_ready = 1'b0;
    $display("txn back-to-back: req=%0d dones=%0d at %0d,%0d rdata=%h,%h", nreq, ndone, d0, d1, rd0, rd1);
    total++; if (nreq !== 2 || r1 !== 5) $display("FAIL b2b_issue: nreq=%0d second at %0d, want 2 at 5", nreq, r1); else passed++;
    total++; if (ndone !== 2 || d0 !== 3 || d1 !== 7) $display("FAIL b2b_done: ndone=%0d at %0d,%0d, want 2 at 3,7", ndone, d0, d1); else passed++;
    total++; if (rd0 !== 64'h8000_0000_0000_0010 || rd1 !== 64'h0000_0000_8000_0000) $display("FAIL b2b_data: got %h,%h want 8000000000000010,0000000080000000", rd0, rd1); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_dword();
    test_load_extend();
    test_store_byte();
    test_align_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
